// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MIPS memory-access stage: size encodings,
// access FSM state type, default wait budget and a misalignment helper.
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is handled as a word too

  localparam int MAX_WAIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // A byte is always aligned; halves need a[0]=0; words (and size 11) need a[1:0]=00.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the access unit. Signal names are seen from the
// access unit: o_* are driven by it, i_* are returned by the memory.
interface mem_access_unit_if #(
  parameter int NB_DATA = 32
);

  logic               o_mem_req;
  logic               o_mem_we;
  logic [NB_DATA-1:0] o_mem_addr;
  logic [NB_DATA-1:0] o_mem_wdata;
  logic [3:0]         o_mem_be;
  logic               i_mem_ready;
  logic [NB_DATA-1:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_ready, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_ready, i_mem_rdata
  );

endinterface

// File: rtl/mem_access_unit_align.sv
// load_store_align: purely combinational lane logic. Produces little-endian
// byte enables and replicated store lanes from the low address bits, and
// extracts/extends the addressed lane of a read word.
module load_store_align
  import mips_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [1:0]         i_addr_lo,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [NB_DATA-1:0] i_store_data,
  input  logic [NB_DATA-1:0] i_rdata,
  output logic [3:0]         o_be,
  output logic [NB_DATA-1:0] o_wdata,
  output logic [NB_DATA-1:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection for enables, store replication and load extension.
  always_comb begin
    o_be        = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_rdata;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SIZE_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {(NB_DATA/8){i_store_data[7:0]}};
        o_load_data = {{(NB_DATA-8){~i_unsigned & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata     = {(NB_DATA/16){i_store_data[15:0]}};
        o_load_data = {{(NB_DATA-16){~i_unsigned & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer. Stalls the pipeline while
// a request is outstanding on the memory bus, pulses o_done for one cycle when
// the access finishes, and aborts with o_timeout after MAX_WAIT BUSY cycles.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned
// halves/words with a one-cycle o_misalign pulse instead of force-aligning them.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_DATA-1:0] i_store_data,
  output logic               o_stall,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_load_data,
  output logic               o_misalign,
  output logic               o_timeout,
  mem_access_unit_if.master  mem_bus
);

  localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [NB_DATA-1:0] r_addr;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic               r_we;
  logic [NB_DATA-1:0] r_wdata;
  logic [3:0]         r_be;
  logic [NB_DATA-1:0] r_load_data;
  logic               r_timeout;

  logic               w_access;
  logic               w_misaligned;
  logic               w_aligned;
  logic               w_start;
  logic               w_timeout_hit;
  logic [NB_DATA-1:0] w_addr;
  logic [1:0]         w_lane_lo;
  logic [1:0]         w_lane_size;
  logic               w_lane_uns;
  logic [3:0]         w_be;
  logic [NB_DATA-1:0] w_wdata;
  logic [NB_DATA-1:0] w_load_ext;

  assign w_access     = i_valid & (i_mem_read | i_mem_write);
  assign w_misaligned = is_misaligned(i_size, i_alu_result[1:0]);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_aligned = ~w_misaligned;
  assign w_addr    = i_alu_result;

  // One-cycle trap pulse registered from the offending presentation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_misalign <= 1'b0;
    else       r_misalign <= (r_state == ST_IDLE) & w_access & w_misaligned;
  end

  assign o_misalign = r_misalign;
`else
  // Misaligned halves/words silently drop the offending low address bits.
  assign w_aligned  = 1'b1;
  assign w_addr     = w_misaligned
                      ? {i_alu_result[NB_DATA-1:2],
                         (i_size == SIZE_HALF) ? {i_alu_result[1], 1'b0} : 2'b00}
                      : i_alu_result;
  assign o_misalign = 1'b0;
`endif

  assign w_start       = (r_state == ST_IDLE) & w_access & w_aligned;
  assign w_timeout_hit = (r_cnt == CNT_LAST);

  // Enables/wdata come from the live inputs in IDLE; load extraction uses captured fields.
  assign w_lane_lo   = (r_state == ST_IDLE) ? w_addr[1:0] : r_addr[1:0];
  assign w_lane_size = (r_state == ST_IDLE) ? i_size      : r_size;
  assign w_lane_uns  = (r_state == ST_IDLE) ? i_unsigned  : r_unsigned;

  load_store_align #(.NB_DATA(NB_DATA)) u_align (
    .i_addr_lo    (w_lane_lo),
    .i_size       (w_lane_size),
    .i_unsigned   (w_lane_uns),
    .i_store_data (i_store_data),
    .i_rdata      (mem_bus.i_mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_ext)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; a ready response takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_BUSY;
      ST_BUSY: if (mem_bus.i_mem_ready | w_timeout_hit) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, wait counting and completion data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_size      <= SIZE_BYTE;
      r_unsigned  <= 1'b0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_be        <= 4'b0000;
      r_load_data <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_cnt      <= '0;
          r_addr     <= w_addr;
          r_size     <= i_size;
          r_unsigned <= i_unsigned;
          r_we       <= i_mem_write;
          r_wdata    <= w_wdata;
          r_be       <= w_be;
          r_timeout  <= 1'b0;
        end
        ST_BUSY: begin
          if (mem_bus.i_mem_ready) begin
            r_load_data <= w_load_ext;
          end else if (w_timeout_hit) begin
            r_load_data <= '0;
            r_timeout   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall is forced low during reset so an aborted access releases the pipeline at once.
  assign o_stall     = ~i_rst & (w_start | (r_state == ST_BUSY));
  assign o_done      = (r_state == ST_DONE);
  assign o_timeout   = (r_state == ST_DONE) & r_timeout;
  assign o_load_data = r_load_data;

  assign mem_bus.o_mem_req   = (r_state == ST_BUSY);
  assign mem_bus.o_mem_we    = (r_state == ST_BUSY) & r_we;
  assign mem_bus.o_mem_addr  = {r_addr[NB_DATA-1:2], 2'b00};
  assign mem_bus.o_mem_wdata = r_wdata;
  assign mem_bus.o_mem_be    = r_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: stores/loads of every size,
// wait states, timeout, non-access cycles, misalignment and mid-access reset.
module tb_mem_access_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, mem_read, mem_write, unsgn;
  logic [1:0]  size;
  logic [31:0] alu_result, store_data;
  logic        o_stall, o_done, o_misalign, o_timeout;
  logic [31:0] o_load_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit_if #(.NB_DATA(32)) mem_bus ();

  mem_access_unit #(.NB_DATA(32), .MAX_WAIT(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_mem_read   (mem_read),
    .i_mem_write  (mem_write),
    .i_size       (size),
    .i_unsigned   (unsgn),
    .i_alu_result (alu_result),
    .i_store_data (store_data),
    .o_stall      (o_stall),
    .o_done       (o_done),
    .o_load_data  (o_load_data),
    .o_misalign   (o_misalign),
    .o_timeout    (o_timeout),
    .mem_bus      (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] data);
    valid      = v;
    mem_read   = rd;
    mem_write  = wr;
    size       = sz;
    unsgn      = uns;
    alu_result = addr;
    store_data = data;
  endtask

  // Presents one access, answers ready after 'waits' BUSY cycles, checks bus and result.
  task automatic run_access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] data,
                            input int waits, input logic [31:0] rdata, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_load);
    int stalls;
    stalls = 0;
    @(negedge clk);
    drive(1'b1, rd, wr, sz, uns, addr, data);
    mem_bus.i_mem_ready = 1'b0;
    mem_bus.i_mem_rdata = 32'h0;
    #1;
    check_eq({tag, "_req_idle"}, 32'(mem_bus.o_mem_req), 32'd0);
    stalls = stalls + int'(o_stall);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      mem_bus.i_mem_ready = (i == waits);
      mem_bus.i_mem_rdata = (i == waits) ? rdata : 32'h0;
      #1;
      check_eq({tag, "_req"}, 32'(mem_bus.o_mem_req), 32'd1);
      if (i == 0) begin
        check_eq({tag, "_addr"}, mem_bus.o_mem_addr, exp_addr);
        check_eq({tag, "_be"}, 32'(mem_bus.o_mem_be), 32'(exp_be));
        check_eq({tag, "_we"}, 32'(mem_bus.o_mem_we), 32'(wr));
        if (wr) check_eq({tag, "_wdata"}, mem_bus.o_mem_wdata, exp_wdata);
      end
      stalls = stalls + int'(o_stall);
    end
    @(negedge clk);
    mem_bus.i_mem_ready = 1'b0;
    mem_bus.i_mem_rdata = 32'h0;
    #1;
    check_eq({tag, "_done"}, 32'(o_done), 32'd1);
    check_eq({tag, "_stall_done"}, 32'(o_stall), 32'd0);
    check_eq({tag, "_timeout"}, 32'(o_timeout), 32'd0);
    check_eq({tag, "_stall_cycles"}, stalls, waits + 2);
    if (rd && !wr) check_eq({tag, "_load"}, o_load_data, exp_load);
    drive(1'b0, 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  busy;
    bit  seen;

    // Reset with an access presented: everything must be quiet.
    rst = 1'b1;
    mem_bus.i_mem_ready = 1'b0;
    mem_bus.i_mem_rdata = 32'h0;
    drive(1'b1, 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h104, 32'hDEADBEEF);
    #12;
    check_eq("rst_stall", 32'(o_stall), 32'd0);
    check_eq("rst_req", 32'(mem_bus.o_mem_req), 32'd0);
    check_eq("rst_we", 32'(mem_bus.o_mem_we), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_timeout", 32'(o_timeout), 32'd0);
    check_eq("rst_misalign", 32'(o_misalign), 32'd0);
    check_eq("rst_load", o_load_data, 32'h0);
    check_eq("rst_addr", mem_bus.o_mem_addr, 32'h0);
    check_eq("rst_wdata", mem_bus.o_mem_wdata, 32'h0);
    check_eq("rst_be", 32'(mem_bus.o_mem_be), 32'h0);
    drive(1'b0, 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Stores and loads of every size, with and without wait states.
    run_access("sw",  1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h104, 32'hDEADBEEF, 0, 32'h0,
               32'h104, 4'b1111, 32'hDEADBEEF, 32'h0);
    run_access("lb",  1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h203, 32'h0, 0, 32'h80AA55CC,
               32'h200, 4'b1000, 32'h0, 32'hFFFFFF80);
    run_access("lbu", 1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h203, 32'h0, 0, 32'h80AA55CC,
               32'h200, 4'b1000, 32'h0, 32'h00000080);
    run_access("sh",  1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h012, 32'h1234ABCD, 3, 32'h0,
               32'h010, 4'b1100, 32'hABCDABCD, 32'h0);
    run_access("sb",  1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h101, 32'h000000A5, 1, 32'h0,
               32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0);
    run_access("lh",  1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h002, 32'h0, 0, 32'h80AA55CC,
               32'h000, 4'b1100, 32'h0, 32'hFFFF80AA);
    run_access("lhu", 1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h000, 32'h0, 1, 32'h80AA55CC,
               32'h000, 4'b0011, 32'h0, 32'h000055CC);
    run_access("lw",  1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h300, 32'h0, 2, 32'h80AA55CC,
               32'h300, 4'b1111, 32'h0, 32'h80AA55CC);
    // Size 11 acts as a word, and write wins when read is also set.
    run_access("sz3", 1'b1, 1'b1, 2'b11, 1'b0, 32'h008, 32'h0BADF00D, 0, 32'h0,
               32'h008, 4'b1111, 32'h0BADF00D, 32'h0);

    // Timeout: no ready ever; previous load data was nonzero.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h200, 32'h0);
    mem_bus.i_mem_ready = 1'b0;
    busy = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (o_done) seen = 1'b1;
      else if (mem_bus.o_mem_req) busy++;
    end
    check_eq("to_done_seen", 32'(seen), 32'd1);
    check_eq("to_busy_cycles", busy, 16);
    check_eq("to_timeout", 32'(o_timeout), 32'd1);
    check_eq("to_load", o_load_data, 32'h0);
    check_eq("to_stall", 32'(o_stall), 32'd0);
    check_eq("to_req", 32'(mem_bus.o_mem_req), 32'd0);
    drive(1'b0, 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check_eq("to_pulse_end", 32'(o_timeout), 32'd0);
    check_eq("to_done_end", 32'(o_done), 32'd0);

    // Non-access cycles.
    drive(1'b1, 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h500, 32'h0);
    #1;
    check_eq("na_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    #1;
    check_eq("na_req", 32'(mem_bus.o_mem_req), 32'd0);
    check_eq("na_done", 32'(o_done), 32'd0);
    drive(1'b0, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h500, 32'h0);
    #1;
    check_eq("nv_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    #1;
    check_eq("nv_req", 32'(mem_bus.o_mem_req), 32'd0);
    drive(1'b0, 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);

    // Misaligned word at 0x102.
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h102, 32'h0);
    #1;
    check_eq("mis_stall", 32'(o_stall), 32'd0);
    check_eq("mis_pulse_early", 32'(o_misalign), 32'd0);
    @(negedge clk);
    #1;
    check_eq("mis_pulse", 32'(o_misalign), 32'd1);
    check_eq("mis_req", 32'(mem_bus.o_mem_req), 32'd0);
    drive(1'b0, 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check_eq("mis_pulse_end", 32'(o_misalign), 32'd0);
    check_eq("mis_req_end", 32'(mem_bus.o_mem_req), 32'd0);
`else
    run_access("lw_mis", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h102, 32'h0, 0, 32'h11223344,
               32'h100, 4'b1111, 32'h0, 32'h11223344);
    check_eq("mis_tied", 32'(o_misalign), 32'd0);
    run_access("lhu_mis", 1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h003, 32'h0, 0, 32'h80AA55CC,
               32'h000, 4'b1100, 32'h0, 32'h000080AA);
`endif

    // Reset in the middle of a BUSY access.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h400, 32'h0);
    mem_bus.i_mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check_eq("mr_req_busy", 32'(mem_bus.o_mem_req), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mr_req", 32'(mem_bus.o_mem_req), 32'd0);
    check_eq("mr_stall", 32'(o_stall), 32'd0);
    drive(1'b0, 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_access("after_rst", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h404, 32'hCAFEF00D, 0, 32'h0,
               32'h404, 4'b1111, 32'hCAFEF00D, 32'h0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
